// File: rtl/pipes_pkg.sv
// Shared pipeline types: the fetch-to-decode payload and the fetch FSM states.
package pipes_pkg;

  localparam logic [63:0] PCINIT_DEFAULT = 64'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] raw_instr;
    logic [63:0] pc;
  } fetch_data_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer that catches a fetched instruction while decode is stalled.
module fetch_skid
  import pipes_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  fetch_data_t din,
  output fetch_data_t dout,
  output logic        full
);

  logic        vld;
  logic [31:0] instr;
  logic [63:0] pc;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      vld <= 1'b0;
    end else if (push) begin
      vld <= din.valid;
    end else if (pop) begin
      vld <= 1'b0;
    end
  end

  // Payload carries no reset; only the valid bit is meaningful after a clear.
  always_ff @(posedge clk) begin
    if (push) begin
      instr <= din.raw_instr;
      pc    <= din.pc;
    end
  end

  assign dout = '{valid: vld, raw_instr: instr, pc: pc};
  assign full = vld;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding bus requester feeding decode through
// a dataF register backed by a one-entry skid buffer.
module fetch_unit
  import pipes_pkg::*;
#(
  parameter logic [63:0] PCINIT = PCINIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output fetch_data_t dataF
);

  fetch_state_t state, state_nxt;
  logic [63:0]  fetch_pc, fetch_pc_nxt;
  logic [63:0]  req_addr, req_addr_nxt;
  logic [63:0]  pc_src;
  logic         drop, drop_nxt;
  fetch_data_t  dataf_nxt, skid_q, resp;
  logic         skid_full, skid_push, skid_pop, skid_full_nxt;
  logic         complete, deliver, open_slot, enter_req;

  assign ireq_valid = (state == S_REQ);
  assign ireq_addr  = req_addr;
  assign resp       = '{valid: 1'b1, raw_instr: iresp_data, pc: req_addr};

  always_comb begin
    complete = 1'b0;
    case (state)
      S_REQ:   complete = iresp_addr_ok && iresp_data_ok;
      S_WAIT:  complete = iresp_data_ok;
      default: complete = 1'b0;
    endcase

    // A redirect in the completing cycle discards that response on the spot.
    deliver       = complete && !drop && !redirect_valid;
    open_slot     = !dataF.valid || !stall;
    skid_pop      = !redirect_valid && open_slot && skid_full;
    skid_push     = deliver && (!open_slot || skid_full);
    skid_full_nxt = !redirect_valid && (skid_push || (skid_full && !skid_pop));

    dataf_nxt = dataF;
    if (redirect_valid) begin
      dataf_nxt.valid = 1'b0;
    end else if (open_slot) begin
      if (skid_full) begin
        dataf_nxt = skid_q;
      end else if (deliver) begin
        dataf_nxt = resp;
      end else begin
        dataf_nxt.valid = 1'b0;
      end
    end

    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = skid_full_nxt ? S_IDLE : S_REQ;
      S_REQ: begin
        if (complete) begin
          state_nxt = skid_full_nxt ? S_IDLE : S_REQ;
        end else if (iresp_addr_ok) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (complete) begin
          state_nxt = skid_full_nxt ? S_IDLE : S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    drop_nxt = drop;
    if (complete) begin
      drop_nxt = 1'b0;
    end else if (redirect_valid && (state != S_IDLE)) begin
      drop_nxt = 1'b1;
    end

    // A new request issued in the redirect cycle goes straight to the target.
    enter_req    = (state_nxt == S_REQ) && ((state != S_REQ) || complete);
    pc_src       = redirect_valid ? redirect_pc : fetch_pc;
    fetch_pc_nxt = pc_src;
    req_addr_nxt = req_addr;
    if (enter_req) begin
      req_addr_nxt = pc_src;
      fetch_pc_nxt = pc_src + 64'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      drop     <= 1'b0;
      fetch_pc <= PCINIT;
      dataF    <= '0;
    end else begin
      state    <= state_nxt;
      drop     <= drop_nxt;
      fetch_pc <= fetch_pc_nxt;
      dataF    <= dataf_nxt;
    end
  end

  always_ff @(posedge clk) begin
    req_addr <= req_addr_nxt;
  end

  fetch_skid u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (skid_push),
    .pop   (skid_pop),
    .flush (redirect_valid),
    .din   (resp),
    .dout  (skid_q),
    .full  (skid_full)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scripted bus responder, program-order model
// of the instruction stream, and hand-computed literal checkpoints.
module tb_fetch_unit;
  import pipes_pkg::*;

  localparam logic [63:0] PCINIT = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  fetch_data_t dataF;

  int n_vec = 0;
  int n_bad = 0;

  // bus responder configuration and state
  int          alat = 0;
  int          dlat = 0;
  int          acnt = 0;
  int          cnt  = 0;
  bit          pending = 1'b0;
  bit          force_dok = 1'b0;
  logic [63:0] pend_addr = '0;

  // checker history
  bit          p_reset = 1'b0;
  bit          p_redir = 1'b0;
  bit          p_hold  = 1'b0;
  bit          p_iv    = 1'b0;
  bit          p_aok   = 1'b0;
  logic [63:0] p_addr  = '0;
  fetch_data_t p_data  = '0;
  logic [63:0] exp_pc  = PCINIT;

  fetch_unit #(.PCINIT(PCINIT)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_addr_ok  (iresp_addr_ok),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .dataF          (dataF)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [63:0] a);
    return {a[17:2], ~a[17:2]} ^ a[63:32] ^ {a[31:18], 16'h0000, a[1:0]};
  endfunction

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_aok(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #2;
      if (iresp_addr_ok && ireq_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, ok, {63'd0, ok}, 64'd1);
  endtask

  task automatic wait_ireq(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (ireq_valid) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    chk(name, ok, {63'd0, ok}, 64'd1);
  endtask

  task automatic wait_dvalid(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (dataF.valid) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    chk(name, ok, {63'd0, ok}, 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
  endtask

  // Bus responder: decides this cycle's response at the falling edge.
  initial begin
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b0;
    iresp_data    = '0;
    forever begin
      @(negedge clk);
      iresp_addr_ok = 1'b0;
      iresp_data_ok = 1'b0;
      iresp_data    = '0;
      if (reset) begin
        pending = 1'b0;
        acnt    = 0;
      end
      if (force_dok) begin
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hDEAD_BEEF;
      end else if (pending) begin
        if (cnt == 0) begin
          iresp_data_ok = 1'b1;
          iresp_data    = mem(pend_addr);
          pending       = 1'b0;
        end else begin
          cnt--;
        end
      end else if (ireq_valid) begin
        if (acnt >= alat) begin
          iresp_addr_ok = 1'b1;
          acnt          = 0;
          if (dlat == 0) begin
            iresp_data_ok = 1'b1;
            iresp_data    = mem(ireq_addr);
          end else begin
            pending   = 1'b1;
            pend_addr = ireq_addr;
            cnt       = dlat - 1;
          end
        end else begin
          acnt++;
        end
      end else if (alat == 0 && dlat == 0) begin
        iresp_addr_ok = 1'b1;
        iresp_data_ok = 1'b1;
        iresp_data    = mem(ireq_addr);
      end
    end
  end

  // Model: decode must see instructions in program order, each with the word
  // stored at its pc; stalls hold dataF, redirects and resets restart the stream.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (p_reset) begin
        chk("reset_dataF", dataF == '0, dataF.pc, 64'd0);
        chk("reset_ireq_valid", ireq_valid == 1'b0, {63'd0, ireq_valid}, 64'd0);
      end else if (p_redir) begin
        chk("redirect_clears_dataF", !dataF.valid, {63'd0, dataF.valid}, 64'd0);
      end else if (p_hold) begin
        chk("stall_hold", dataF == p_data, dataF.pc, p_data.pc);
      end
      if (!p_reset && p_iv && !p_aok) begin
        chk("ireq_addr_stable", ireq_valid && (ireq_addr == p_addr), ireq_addr, p_addr);
      end
      if (reset) begin
        exp_pc = PCINIT;
      end else begin
        if (dataF.valid && !stall) begin
          chk("order_pc", dataF.pc == exp_pc, dataF.pc, exp_pc);
          chk("instr_word", dataF.raw_instr == mem(dataF.pc), {32'd0, dataF.raw_instr},
              {32'd0, mem(dataF.pc)});
          exp_pc = exp_pc + 64'd4;
        end
        if (redirect_valid) exp_pc = redirect_pc;
      end
      p_reset = reset;
      p_redir = redirect_valid && !reset;
      p_hold  = dataF.valid && stall && !redirect_valid && !reset;
      p_iv    = ireq_valid;
      p_aok   = iresp_addr_ok;
      p_addr  = ireq_addr;
      p_data  = dataF;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (3) cyc();
    chk("rst_ireq_valid", ireq_valid == 1'b0, {63'd0, ireq_valid}, 64'd0);
    chk("rst_dataF_zero", dataF == '0, dataF.pc, 64'd0);

    // zero-wait streaming from reset
    reset = 1'b0;
    cyc();
    chk("first_req_valid", ireq_valid == 1'b1, {63'd0, ireq_valid}, 64'd1);
    chk("first_req_addr", ireq_addr == 64'h8000_0000, ireq_addr, 64'h8000_0000);
    cyc();
    chk("zw_pc0", dataF.valid && dataF.pc == 64'h8000_0000, dataF.pc, 64'h8000_0000);
    chk("zw_instr0", dataF.raw_instr == 32'h8000_FFFF, {32'd0, dataF.raw_instr}, 64'h8000_FFFF);
    cyc();
    chk("zw_pc1", dataF.valid && dataF.pc == 64'h8000_0004, dataF.pc, 64'h8000_0004);
    chk("zw_instr1", dataF.raw_instr == 32'h8001_FFFE, {32'd0, dataF.raw_instr}, 64'h8001_FFFE);
    cyc();
    chk("zw_pc2", dataF.valid && dataF.pc == 64'h8000_0008, dataF.pc, 64'h8000_0008);
    chk("zw_instr2", dataF.raw_instr == 32'h8002_FFFD, {32'd0, dataF.raw_instr}, 64'h8002_FFFD);

    // stall three cycles while dataF holds 0x80000004
    do_reset();
    cyc();
    cyc();
    cyc();
    chk("stall_pre_pc", dataF.valid && dataF.pc == 64'h8000_0004, dataF.pc, 64'h8000_0004);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_dataF_pc", dataF.valid && dataF.pc == 64'h8000_0004, dataF.pc, 64'h8000_0004);
      chk("stall_no_req", ireq_valid == 1'b0, {63'd0, ireq_valid}, 64'd0);
    end
    stall = 1'b0;
    cyc();
    chk("skid_drain_pc", dataF.valid && dataF.pc == 64'h8000_0008, dataF.pc, 64'h8000_0008);
    chk("resume_req_addr", ireq_valid && ireq_addr == 64'h8000_000C, ireq_addr, 64'h8000_000C);
    cyc();
    chk("resume_pc", dataF.valid && dataF.pc == 64'h8000_000C, dataF.pc, 64'h8000_000C);

    // addr_ok two cycles late, data_ok three cycles after acceptance
    alat = 2;
    dlat = 3;
    wait_aok("lat_aok_seen");
    chk("lat_req_addr", ireq_addr == 64'h8000_0010, ireq_addr, 64'h8000_0010);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk("lat_dataF_empty", !dataF.valid, {63'd0, dataF.valid}, 64'd0);
    end
    cyc();
    chk("lat_dataF_n4", dataF.valid && dataF.pc == 64'h8000_0010, dataF.pc, 64'h8000_0010);

    // redirect while waiting for data
    alat = 0;
    dlat = 3;
    wait_aok("wait_aok_seen");
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    cyc();
    redirect_valid = 1'b0;
    chk("wait_redir_no_req", ireq_valid == 1'b0, {63'd0, ireq_valid}, 64'd0);
    wait_ireq("wait_redir_req_seen");
    chk("wait_redir_addr", ireq_addr == 64'h8000_0100, ireq_addr, 64'h8000_0100);
    wait_dvalid("wait_redir_data_seen");
    chk("wait_redir_pc", dataF.pc == 64'h8000_0100, dataF.pc, 64'h8000_0100);

    // fill dataF and skid under stall, then redirect with stall still high
    stall = 1'b1;
    dlat  = 0;
    repeat (8) cyc();
    chk("full_hold_pc", dataF.valid && dataF.pc == 64'h8000_0100, dataF.pc, 64'h8000_0100);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    cyc();
    redirect_valid = 1'b0;
    chk("stall_redir_clear", !dataF.valid, {63'd0, dataF.valid}, 64'd0);
    chk("stall_redir_req", ireq_valid && ireq_addr == 64'h8000_0200, ireq_addr, 64'h8000_0200);
    stall = 1'b0;
    cyc();
    chk("stall_redir_pc", dataF.valid && dataF.pc == 64'h8000_0200, dataF.pc, 64'h8000_0200);

    // reset while waiting, stale data_ok during and just after reset
    dlat = 5;
    wait_aok("rst_wait_aok_seen");
    cyc();
    reset     = 1'b1;
    force_dok = 1'b1;
    cyc();
    chk("midrst_ireq_valid", ireq_valid == 1'b0, {63'd0, ireq_valid}, 64'd0);
    chk("midrst_dataF", dataF == '0, dataF.pc, 64'd0);
    cyc();
    reset = 1'b0;
    alat  = 3;
    dlat  = 0;
    cyc();
    force_dok = 1'b0;
    chk("post_rst_addr", ireq_valid && ireq_addr == 64'h8000_0000, ireq_addr, 64'h8000_0000);
    chk("post_rst_no_stale", !dataF.valid, {63'd0, dataF.valid}, 64'd0);

    // redirect while the request is still unaccepted
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0300;
    cyc();
    redirect_valid = 1'b0;
    chk("req_redir_addr_held", ireq_valid && ireq_addr == 64'h8000_0000, ireq_addr, 64'h8000_0000);
    wait_aok("req_redir_aok_seen");
    cyc();
    chk("req_redir_new_addr", ireq_valid && ireq_addr == 64'h8000_0300, ireq_addr, 64'h8000_0300);
    chk("req_redir_dropped", !dataF.valid, {63'd0, dataF.valid}, 64'd0);
    wait_dvalid("req_redir_data_seen");
    chk("req_redir_pc", dataF.pc == 64'h8000_0300, dataF.pc, 64'h8000_0300);
    chk("req_redir_instr", dataF.raw_instr == 32'h80C0_FF3F, {32'd0, dataF.raw_instr}, 64'h80C0_FF3F);

    repeat (6) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
